// File: rtl/active_pixel_loader.sv
// Purpose : serializes packed pixel-enable words into 1-bit writes of the back bank of a ping-pong bitmap; swaps banks on line sync.
// Latency : first write one cycle after a word is accepted; line_loaded_o LINE_PIXELS+1 cycles after the first accept (continuous valid).
// Backpressure: s_ready_o high in LOAD and on the last bit of a non-final word; low while shifting and while a full line waits for sync.
//
// Ports:
//   clk_i, rstn_i          clock, async active-low reset
//   s_data_i/s_valid_i/s_ready_o   pixel word stream, bit 0 = lowest address
//   line_sync_i            scan-side start-of-line pulse
//   clr_underrun_i         clears the sticky underrun flag
//   waddr_o/wdata_o/wen_o  1-bit bank write port
//   mem_selector_o         1 = bank 1 written / bank 0 read, 0 = reverse
//   line_loaded_o          back bank holds a complete line awaiting swap
//   underrun_o             sticky: sync arrived before the line was complete
module active_pixel_loader #(
  parameter int ADDR_W      = 9,
  parameter int LINE_PIXELS = 512,
  parameter int WORD_W      = 32
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic [WORD_W-1:0] s_data_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic              line_sync_i,
  input  logic              clr_underrun_i,
  output logic [ADDR_W-1:0] waddr_o,
  output logic              wdata_o,
  output logic              wen_o,
  output logic              mem_selector_o,
  output logic              line_loaded_o,
  output logic              underrun_o
);

  localparam int CNT_W = $clog2(WORD_W) + 1;
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(LINE_PIXELS - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(WORD_W);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [WORD_W-1:0] shreg, shreg_nxt;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic [ADDR_W-1:0] pix_cnt, pix_cnt_nxt;
  logic              sel_q, sel_nxt;
  logic              underrun_q, underrun_set;
  logic              wen_q, loaded_q;
  logic              last_bit, line_end;

  // LINE_PIXELS is a multiple of WORD_W, so the final pixel of a line is
  // always the final bit of a word.
  assign last_bit = (bit_cnt == CNT_ONE);
  assign line_end = last_bit && (pix_cnt == LAST_PIX);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= LOAD;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    shreg_nxt    = shreg;
    bit_cnt_nxt  = bit_cnt;
    pix_cnt_nxt  = pix_cnt;
    sel_nxt      = sel_q;
    underrun_set = 1'b0;
    s_ready_o    = 1'b0;
    case (state)
      LOAD: begin
        s_ready_o = 1'b1;
        if (s_valid_i) begin
          shreg_nxt   = s_data_i;
          bit_cnt_nxt = CNT_FULL;
          state_nxt   = SHIFT;
        end
        // Line incomplete: scan side keeps re-reading the old bank.
        if (line_sync_i) underrun_set = 1'b1;
      end
      SHIFT: begin
        shreg_nxt   = shreg >> 1;
        bit_cnt_nxt = bit_cnt - CNT_ONE;
        pix_cnt_nxt = pix_cnt + ADDR_W'(1);
        if (line_end) begin
          pix_cnt_nxt = '0;
          // A sync landing on the final write swaps immediately: that write
          // still commits to the current back bank, and FULL is skipped.
          if (line_sync_i) begin
            sel_nxt   = ~sel_q;
            state_nxt = LOAD;
          end else begin
            state_nxt = FULL;
          end
        end else begin
          if (line_sync_i) underrun_set = 1'b1;
          if (last_bit) begin
            // Accept the next word on the same edge so writes stay gapless.
            s_ready_o = 1'b1;
            if (s_valid_i) begin
              shreg_nxt   = s_data_i;
              bit_cnt_nxt = CNT_FULL;
            end else begin
              state_nxt = LOAD;
            end
          end
        end
      end
      FULL: begin
        if (line_sync_i) begin
          sel_nxt     = ~sel_q;
          pix_cnt_nxt = '0;
          state_nxt   = LOAD;
        end
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      pix_cnt    <= '0;
      sel_q      <= 1'b0;
      underrun_q <= 1'b0;
      wen_q      <= 1'b0;
      loaded_q   <= 1'b0;
    end else begin
      shreg      <= shreg_nxt;
      bit_cnt    <= bit_cnt_nxt;
      pix_cnt    <= pix_cnt_nxt;
      sel_q      <= sel_nxt;
      // Set has priority over clear.
      underrun_q <= underrun_set | (underrun_q & ~clr_underrun_i);
      wen_q      <= (state_nxt == SHIFT);
      loaded_q   <= (state_nxt == FULL);
    end
  end

  // In SHIFT, pix_cnt is the address of the bit currently at shreg[0].
  assign waddr_o        = pix_cnt;
  assign wdata_o        = shreg[0];
  assign wen_o          = wen_q;
  assign mem_selector_o = sel_q;
  assign line_loaded_o  = loaded_q;
  assign underrun_o     = underrun_q;

endmodule

// File: tb/tb_active_pixel_loader.sv
// Purpose : randomized scoreboard bench for active_pixel_loader.
// Latency : a reference model predicts every (addr, data, bank, idle gap) write at word accept.
// Backpressure: the driver honours s_ready_o; a monitor pops and compares on each wen_o.
module tb_active_pixel_loader;

  localparam int LINE = 512;
  localparam int WW   = 32;

  logic          clk_i;
  logic          rstn_i;
  logic [WW-1:0] s_data_i;
  logic          s_valid_i;
  logic          s_ready_o;
  logic          line_sync_i;
  logic          clr_underrun_i;
  logic [8:0]    waddr_o;
  logic          wdata_o;
  logic          wen_o;
  logic          mem_selector_o;
  logic          line_loaded_o;
  logic          underrun_o;

  active_pixel_loader dut (
    .clk_i          (clk_i),
    .rstn_i         (rstn_i),
    .s_data_i       (s_data_i),
    .s_valid_i      (s_valid_i),
    .s_ready_o      (s_ready_o),
    .line_sync_i    (line_sync_i),
    .clr_underrun_i (clr_underrun_i),
    .waddr_o        (waddr_o),
    .wdata_o        (wdata_o),
    .wen_o          (wen_o),
    .mem_selector_o (mem_selector_o),
    .line_loaded_o  (line_loaded_o),
    .underrun_o     (underrun_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [8:0] addr;
    logic       data;
    logic       sel;
    int         gap;   // expected idle cycles before this write, -1 = unchecked
  } exp_t;

  exp_t sbq[$];
  int   n_cmp     = 0;
  int   n_bad     = 0;
  int   cyc       = 0;
  int   last_wr   = 0;
  int   acc_cyc   = 0;
  int   model_pix = 0;
  logic model_sel = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write must match the oldest predicted write.
  always @(negedge clk_i) begin
    if (rstn_i && wen_o) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: addr 0x%0h with no predicted write (cycle %0d)", waddr_o, cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("wr_addr_data_sel", {21'd0, waddr_o, wdata_o, mem_selector_o}, {21'd0, e.addr, e.data, e.sel});
        if (e.gap >= 0) check("wr_idle_gap", cyc - last_wr - 1, e.gap);
      end
      last_wr = cyc;
    end
  end

  // Call at a negedge; returns at the negedge after the accepting edge.
  task automatic send_word(input logic [WW-1:0] w, input int gap);
    int n;
    n = 0;
    s_data_i  = w;
    s_valid_i = 1'b1;
    while (!s_ready_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    if (!s_ready_o) begin
      check("send_ready_timeout", {31'd0, s_ready_o}, 32'd1);
    end else begin
      if (model_pix == 0) acc_cyc = cyc;
      for (int i = 0; i < WW; i++) begin
        exp_t e;
        e.addr = model_pix[8:0];
        e.data = w[i];
        e.sel  = model_sel;
        e.gap  = (i == 0) ? gap : 0;
        sbq.push_back(e);
        model_pix = (model_pix + 1) % LINE;
      end
    end
    @(negedge clk_i);
    s_valid_i = 1'b0;
  endtask

  // gap_mode: after each word, wait for LOAD, stall 5 cycles, then re-offer.
  task automatic send_line(input bit gap_mode, input logic [WW-1:0] fixed, input bit use_fixed);
    for (int k = 0; k < LINE / WW; k++) begin
      logic [WW-1:0] w;
      w = use_fixed ? fixed : $urandom;
      if (k > 0 && gap_mode) begin
        int n;
        n = 0;
        do begin
          @(negedge clk_i);
          n++;
        end while (!(s_ready_o && !wen_o) && n < 200);
        repeat (5) @(negedge clk_i);
      end
      send_word(w, (k == 0) ? -1 : (gap_mode ? 6 : 0));
    end
  endtask

  task automatic wait_wr(input int a, output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    while (n < 5000) begin
      @(negedge clk_i);
      if (wen_o && waddr_o == a[8:0]) begin
        ok = 1'b1;
        break;
      end
      n++;
    end
  endtask

  task automatic pulse_sync();
    line_sync_i = 1'b1;
    @(negedge clk_i);
    line_sync_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    rstn_i         = 1'b0;
    s_data_i       = '0;
    s_valid_i      = 1'b0;
    line_sync_i    = 1'b0;
    clr_underrun_i = 1'b0;
    repeat (3) @(negedge clk_i);

    check("rst_waddr",    {23'd0, waddr_o}, 32'd0);
    check("rst_wdata",    {31'd0, wdata_o}, 32'd0);
    check("rst_wen",      {31'd0, wen_o}, 32'd0);
    check("rst_sel",      {31'd0, mem_selector_o}, 32'd0);
    check("rst_loaded",   {31'd0, line_loaded_o}, 32'd0);
    check("rst_underrun", {31'd0, underrun_o}, 32'd0);
    check("rst_ready",    {31'd0, s_ready_o}, 32'd1);
    rstn_i = 1'b1;
    @(negedge clk_i);

    // Back-to-back fixed pattern line.
    send_line(1'b0, 32'h0F0F_A5A5, 1'b1);
    wait_wr(LINE - 1, ok);
    check("line1_last_write_seen", {31'd0, ok}, 32'd1);
    @(negedge clk_i);
    check("line1_loaded",  {31'd0, line_loaded_o}, 32'd1);
    check("line1_ready",   {31'd0, s_ready_o}, 32'd0);
    check("line1_wen_off", {31'd0, wen_o}, 32'd0);
    check("line1_latency", cyc - acc_cyc, LINE + 1);
    repeat (3) @(negedge clk_i);
    check("line1_hold_loaded", {31'd0, line_loaded_o}, 32'd1);

    // Swap.
    pulse_sync();
    model_sel = ~model_sel;
    check("swap1_sel",      {31'd0, mem_selector_o}, {31'd0, model_sel});
    check("swap1_loaded",   {31'd0, line_loaded_o}, 32'd0);
    check("swap1_ready",    {31'd0, s_ready_o}, 32'd1);
    check("swap1_underrun", {31'd0, underrun_o}, 32'd0);

    // Random words with stream gaps.
    send_line(1'b1, '0, 1'b0);
    wait_wr(LINE - 1, ok);
    check("gap_last_write_seen", {31'd0, ok}, 32'd1);
    @(negedge clk_i);
    check("gap_loaded", {31'd0, line_loaded_o}, 32'd1);
    pulse_sync();
    model_sel = ~model_sel;
    check("swap2_sel", {31'd0, mem_selector_o}, {31'd0, model_sel});

    // Underrun: sync while writing address 100.
    fork
      send_line(1'b0, '0, 1'b0);
      begin
        bit ok_u;
        wait_wr(100, ok_u);
        check("under_addr100_seen", {31'd0, ok_u}, 32'd1);
        pulse_sync();
        check("under_flag", {31'd0, underrun_o}, 32'd1);
        check("under_sel_kept", {31'd0, mem_selector_o}, {31'd0, model_sel});
      end
    join
    wait_wr(LINE - 1, ok);
    check("under_last_write_seen", {31'd0, ok}, 32'd1);
    @(negedge clk_i);
    check("under_loaded", {31'd0, line_loaded_o}, 32'd1);
    check("under_sticky", {31'd0, underrun_o}, 32'd1);
    clr_underrun_i = 1'b1;
    @(negedge clk_i);
    clr_underrun_i = 1'b0;
    check("under_cleared", {31'd0, underrun_o}, 32'd0);
    pulse_sync();
    model_sel = ~model_sel;
    check("swap3_sel", {31'd0, mem_selector_o}, {31'd0, model_sel});
    // Sync while idle in LOAD, with clear in the same cycle: set wins.
    clr_underrun_i = 1'b1;
    line_sync_i    = 1'b1;
    @(negedge clk_i);
    clr_underrun_i = 1'b0;
    line_sync_i    = 1'b0;
    check("set_beats_clear", {31'd0, underrun_o}, 32'd1);
    check("idle_sync_sel_kept", {31'd0, mem_selector_o}, {31'd0, model_sel});
    clr_underrun_i = 1'b1;
    @(negedge clk_i);
    clr_underrun_i = 1'b0;
    check("under_cleared2", {31'd0, underrun_o}, 32'd0);

    // Asynchronous reset in the middle of a line.
    fork
      for (int k = 0; k < 7; k++) send_word($urandom, (k == 0) ? -1 : 0);
      begin
        bit ok_r;
        wait_wr(200, ok_r);
        check("mid_addr200_seen", {31'd0, ok_r}, 32'd1);
        #1;
        rstn_i = 1'b0;
        #1;
        check("mid_rst_waddr",    {23'd0, waddr_o}, 32'd0);
        check("mid_rst_wen",      {31'd0, wen_o}, 32'd0);
        check("mid_rst_sel",      {31'd0, mem_selector_o}, 32'd0);
        check("mid_rst_loaded",   {31'd0, line_loaded_o}, 32'd0);
        check("mid_rst_underrun", {31'd0, underrun_o}, 32'd0);
        check("mid_rst_ready",    {31'd0, s_ready_o}, 32'd1);
      end
    join
    @(negedge clk_i);
    sbq.delete();
    model_pix = 0;
    model_sel = 1'b0;
    rstn_i    = 1'b1;
    @(negedge clk_i);

    // Sync coincident with the write of the last address.
    fork
      send_line(1'b0, '0, 1'b0);
      begin
        bit ok_c;
        wait_wr(LINE - 1, ok_c);
        check("coin_last_write_seen", {31'd0, ok_c}, 32'd1);
        pulse_sync();
        model_sel = ~model_sel;
        check("coin_sel",      {31'd0, mem_selector_o}, {31'd0, model_sel});
        check("coin_no_full",  {31'd0, line_loaded_o}, 32'd0);
        check("coin_underrun", {31'd0, underrun_o}, 32'd0);
        check("coin_ready",    {31'd0, s_ready_o}, 32'd1);
        check("coin_wen_off",  {31'd0, wen_o}, 32'd0);
        @(negedge clk_i);
        check("coin_no_full_later", {31'd0, line_loaded_o}, 32'd0);
      end
    join

    check("scoreboard_drained", sbq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/active_pixel_loader.md
Name: active_pixel_loader

Overview:
- Write-side feeder for the ping-pong active-pixel bitmap memory (two 512x1 banks, one written while the other is read).
- Accepts packed pixel-enable words on a valid/ready stream and serializes them into 1-bit writes at consecutive addresses of the back bank.
- Holds the completed line until the scan side pulses line sync, then flips the bank selector so the new line becomes the read bank.

Parameters:
ADDR_W, 9, write address width
LINE_PIXELS, 512, pixels per line; must be a multiple of WORD_W and <= 2**ADDR_W
WORD_W, 32, stream word width; must be a power of two

Ports:
clk_i  in  1  clock, single domain
rstn_i  in  1  reset, asynchronous, active-low
s_data_i  in  WORD_W  packed pixel bits; bit 0 is the lowest address
s_valid_i  in  1  stream word valid
s_ready_o  out  1  stream word accepted when s_valid_i & s_ready_o at a rising edge
line_sync_i  in  1  single-cycle pulse from the scan side at the start of each line
clr_underrun_i  in  1  clears underrun_o
waddr_o  out  ADDR_W  memory write address
wdata_o  out  1  memory write data
wen_o  out  1  memory write enable
mem_selector_o  out  1  bank select; 1 = bank 1 written and bank 0 read, 0 = the reverse
line_loaded_o  out  1  back bank holds a complete line awaiting swap
underrun_o  out  1  sticky: line_sync_i arrived before the line was complete

Behaviour:
- Reset (async assert, sync release): state LOAD, pix_cnt=0, bit_cnt=0. Outputs: waddr_o=0, wdata_o=0, wen_o=0, mem_selector_o=0, line_loaded_o=0, underrun_o=0, s_ready_o=1.
- Asserting reset mid-line aborts the line. Partial bank contents are don't-care, and the selector returns to 0.
- All outputs are driven directly from registers except s_ready_o, which is a combinational decode of state, bit_cnt and pix_cnt.
- States: LOAD, SHIFT, FULL.
- LOAD:
  - s_ready_o=1.
  - On accept: shreg<=s_data_i, bit_cnt<=WORD_W, go to SHIFT.
- SHIFT: one write per cycle.
  - wen_o=1, wdata_o=shreg[0], waddr_o=pix_cnt.
  - Each cycle: shreg shifts right, pix_cnt and bit_cnt advance.
  - First write appears in the cycle after the accepting edge.
- Last bit of a word (bit_cnt==1):
  - If pix_cnt != LINE_PIXELS-1: s_ready_o=1, so the next word can be accepted that same edge. With continuous valid, wen_o stays high for LINE_PIXELS consecutive cycles. Without a word, go to LOAD.
  - If pix_cnt == LINE_PIXELS-1: s_ready_o=0, go to FULL.
- FULL:
  - line_loaded_o=1, s_ready_o=0, wen_o=0.
  - On line_sync_i: mem_selector_o toggles, pix_cnt<=0, line_loaded_o<=0, go to LOAD.
- line_sync_i in LOAD or SHIFT (line incomplete):
  - underrun_o<=1; selector is unchanged.
  - Loading continues uninterrupted, and the scan side re-reads the old line.
- line_sync_i in the same cycle as the write to address LINE_PIXELS-1:
  - That write commits under the old selector.
  - Selector toggles at that edge, pix_cnt<=0, go directly to LOAD.
  - No FULL cycle and no underrun.
- clr_underrun_i together with an underrun set: set wins.
- waddr_o wraps only through the pix_cnt reset at line end; it never exceeds LINE_PIXELS-1.
- Line load latency with continuous valid: LINE_PIXELS+1 cycles from the first accept to line_loaded_o.

Test Plan:
- Reset check: hold rstn_i low -> waddr_o=0, wen_o=0, mem_selector_o=0, line_loaded_o=0, underrun_o=0, s_ready_o=1.
- Back-to-back load: 16 words of 0x0F0F_A5A5 with valid held high -> wen_o high for 512 consecutive cycles, waddr_o 0..511, wdata_o pattern 1,0,1,0,0,1,0,1,... LSB-first per word. line_loaded_o=1 the cycle after address 511; s_ready_o=0.
- Swap: pulse line_sync_i in FULL -> mem_selector_o 0->1 next edge, line_loaded_o=0, s_ready_o=1. The next line writes addr 0 upward.
- Stream gaps: drop s_valid_i for 5 cycles after every word -> wen_o gaps of 6 cycles (5 stalled plus 1 LOAD re-accept). Addresses contiguous, no repeats, line completes at 511.
- Underrun: line_sync_i while writing address 100 -> underrun_o=1, selector unchanged, writes continue to 511. Then clr_underrun_i -> underrun_o=0. Clear and sync in the same cycle -> underrun_o stays 1.
- Coincident sync: line_sync_i in the cycle writing address 511 -> selector toggles at that edge, no FULL cycle, underrun_o=0. Async reset at address 200 -> all outputs back to reset values immediately.
